// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: register word offsets, CTRL/STATUS bit
// positions, counting mode and direction encodings.
package pwm_pkg;

   localparam int REG_CTRL     = 0;
   localparam int REG_PERIOD   = 1;
   localparam int REG_PRESCALE = 2;
   localparam int REG_STATUS   = 3;
   localparam int REG_DUTY0    = 4;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_MODE  = 1;
   localparam int CTRL_POL   = 2;
   localparam int CTRL_IRQEN = 3;
   localparam int CTRL_W     = 4;

   localparam int STAT_WRAP = 0;

   typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTRE = 1'b1} pwm_mode_e;
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;

   function automatic int addr_width(input int num_ch);
      return $clog2(num_ch + 4);
   endfunction

endpackage

// File: rtl/pwm_if.sv
// Avalon-MM slave bus bundle for the PWM block; the CPU-side bridge owns the master modport.
interface pwm_avs_if #(
   parameter int NUM_CH = 8
) ();
   import pwm_pkg::*;

   localparam int ADDR_W = addr_width(NUM_CH);

   logic [ADDR_W-1:0] avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;

   modport master (
      output avs_address,
      output avs_write,
      output avs_writedata,
      output avs_read,
      input  avs_readdata
   );

   modport slave (
      input  avs_address,
      input  avs_write,
      input  avs_writedata,
      input  avs_read,
      output avs_readdata
   );

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/centre counter with direction, active PERIOD/mode
// copies and the period-boundary pulse that also drives the shadow commit.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_enable,
   input  pwm_mode_e             i_mode_sh,
   input  logic [CNT_W-1:0]      i_period_sh,
   input  logic [PRESCALE_W-1:0] i_prescale,
   output logic [CNT_W-1:0]      o_cnt,
   output logic                  o_boundary,
   output logic                  o_commit
);

   logic [PRESCALE_W-1:0] r_presc;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      r_period;
   logic [CNT_W-1:0]      w_cnt_nxt;
   pwm_dir_e              r_dir;
   pwm_dir_e              w_dir_nxt;
   pwm_mode_e             r_mode;
   logic                  w_tick;
   logic                  w_bnd;

   // Counter step for one tick; a down-count from 1 to 0 closes a centre-aligned period.
   always_comb begin
      w_tick    = i_enable && (r_presc >= i_prescale);
      w_cnt_nxt = r_cnt;
      w_dir_nxt = r_dir;
      w_bnd     = 1'b0;
      if (r_period == {CNT_W{1'b0}}) begin
         w_cnt_nxt = {CNT_W{1'b0}};
         w_dir_nxt = DIR_UP;
         w_bnd     = 1'b1;
      end else if (r_mode == MODE_EDGE) begin
         w_dir_nxt = DIR_UP;
         if (r_cnt >= r_period) begin
            w_cnt_nxt = {CNT_W{1'b0}};
            w_bnd     = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end else if ((r_dir == DIR_UP) && (r_cnt < r_period)) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
         w_cnt_nxt = r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            w_dir_nxt = DIR_UP;
            w_bnd     = 1'b1;
         end else begin
            w_dir_nxt = DIR_DOWN;
         end
      end
   end

   assign o_boundary = w_tick && w_bnd;
   assign o_commit   = !i_enable || o_boundary;
   assign o_cnt      = r_cnt;

   // Prescaler/counter state; the commit uses the shadow as it stood before this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc  <= {PRESCALE_W{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
         r_dir    <= DIR_UP;
         r_period <= {CNT_W{1'b0}};
         r_mode   <= MODE_EDGE;
      end else begin
         if (!i_enable) begin
            r_presc <= {PRESCALE_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_dir   <= DIR_UP;
         end else if (w_tick) begin
            r_presc <= {PRESCALE_W{1'b0}};
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
         end else begin
            r_presc <= r_presc + PRESCALE_W'(1);
         end
         if (o_commit) begin
            r_period <= i_period_sh;
            r_mode   <= i_mode_sh;
         end
      end
   end

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM with Avalon-MM register file, double-buffered PERIOD/mode/DUTY,
// sticky wrap status with level interrupt, and registered polarity-adjusted outputs.
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int CNT_W      = 16,
   parameter int PRESCALE_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   pwm_avs_if.slave          avs,
   output logic              irq,
   output logic [NUM_CH-1:0] pwm_out
);

   localparam int ADDR_W = addr_width(NUM_CH);

   logic [ADDR_W-1:0]     w_addr;
   logic [31:0]           w_wdata;
   logic                  w_unused_wdata;
   logic [CTRL_W-1:0]     r_ctrl;
   logic [CTRL_W-1:0]     w_ctrl_nxt;
   logic [CNT_W-1:0]      r_period_sh;
   logic [PRESCALE_W-1:0] r_prescale;
   logic                  r_wrap;
   logic                  w_wrap_nxt;
   logic [CNT_W-1:0]      r_duty_sh  [NUM_CH];
   logic [CNT_W-1:0]      r_duty_act [NUM_CH];
   logic [31:0]           r_readdata;
   logic [31:0]           w_rdata;
   logic [31:0]           w_rd_duty;
   logic                  r_irq;
   logic [NUM_CH-1:0]     r_pwm_out;
   logic [NUM_CH-1:0]     w_raw;
   logic [NUM_CH-1:0]     w_pol_vec;
   logic                  w_wr_ctrl;
   logic                  w_wr_period;
   logic                  w_wr_prescale;
   logic                  w_wr_status;
   logic                  w_commit;
   logic                  w_boundary;
   logic [CNT_W-1:0]      w_cnt;
   pwm_mode_e             w_mode_sh;

   assign w_addr         = avs.avs_address;
   assign w_wdata        = avs.avs_writedata;
   assign w_unused_wdata = ^avs.avs_writedata;
   assign w_mode_sh      = pwm_mode_e'(r_ctrl[CTRL_MODE]);
   assign w_pol_vec      = {NUM_CH{r_ctrl[CTRL_POL]}};

   pwm_timebase #(
      .CNT_W      (CNT_W),
      .PRESCALE_W (PRESCALE_W)
   ) u_timebase (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_enable    (r_ctrl[CTRL_EN]),
      .i_mode_sh   (w_mode_sh),
      .i_period_sh (r_period_sh),
      .i_prescale  (r_prescale),
      .o_cnt       (w_cnt),
      .o_boundary  (w_boundary),
      .o_commit    (w_commit)
   );

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
      assign w_raw[g] = (w_cnt < r_duty_act[g]);
   end

   // Write decode, wrap set/clear priority and readback mux (shadow copies are read back).
   always_comb begin
      w_wr_ctrl     = avs.avs_write && (w_addr == ADDR_W'(REG_CTRL));
      w_wr_period   = avs.avs_write && (w_addr == ADDR_W'(REG_PERIOD));
      w_wr_prescale = avs.avs_write && (w_addr == ADDR_W'(REG_PRESCALE));
      w_wr_status   = avs.avs_write && (w_addr == ADDR_W'(REG_STATUS));
      w_wrap_nxt    = (r_wrap && !(w_wr_status && w_wdata[STAT_WRAP])) || w_boundary;
      if (w_wr_ctrl) begin
         w_ctrl_nxt = w_wdata[CTRL_W-1:0];
      end else begin
         w_ctrl_nxt = r_ctrl;
      end
      w_rd_duty = 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_rd_duty = w_rd_duty |
                     ((w_addr == ADDR_W'(REG_DUTY0 + i)) ? 32'(r_duty_sh[i]) : 32'd0);
      end
      case (w_addr)
         ADDR_W'(REG_CTRL):     w_rdata = 32'(r_ctrl);
         ADDR_W'(REG_PERIOD):   w_rdata = 32'(r_period_sh);
         ADDR_W'(REG_PRESCALE): w_rdata = 32'(r_prescale);
         ADDR_W'(REG_STATUS):   w_rdata = {31'd0, r_wrap};
         default:               w_rdata = w_rd_duty;
      endcase
   end

   // Register file, active duty copies, read data, irq and channel outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl      <= {CTRL_W{1'b0}};
         r_period_sh <= {CNT_W{1'b0}};
         r_prescale  <= {PRESCALE_W{1'b0}};
         r_wrap      <= 1'b0;
         r_readdata  <= 32'd0;
         r_irq       <= 1'b0;
         r_pwm_out   <= {NUM_CH{1'b0}};
         for (int i = 0; i < NUM_CH; i++) begin
            r_duty_sh[i]  <= {CNT_W{1'b0}};
            r_duty_act[i] <= {CNT_W{1'b0}};
         end
      end else begin
         r_ctrl <= w_ctrl_nxt;
         if (w_wr_period) begin
            r_period_sh <= w_wdata[CNT_W-1:0];
         end
         if (w_wr_prescale) begin
            r_prescale <= w_wdata[PRESCALE_W-1:0];
         end
         r_wrap <= w_wrap_nxt;
         // irq tracks wrap & irq_en with no extra cycle of lag.
         r_irq  <= w_wrap_nxt && w_ctrl_nxt[CTRL_IRQEN];
         for (int i = 0; i < NUM_CH; i++) begin
            if (avs.avs_write && (w_addr == ADDR_W'(REG_DUTY0 + i))) begin
               r_duty_sh[i] <= w_wdata[CNT_W-1:0];
            end
            if (w_commit) begin
               r_duty_act[i] <= r_duty_sh[i];
            end
         end
         r_readdata <= avs.avs_read ? w_rdata : 32'd0;
         r_pwm_out  <= r_ctrl[CTRL_EN] ? (w_raw ^ w_pol_vec) : w_pol_vec;
      end
   end

   assign avs.avs_readdata = r_readdata;
   assign irq              = r_irq;
   assign pwm_out          = r_pwm_out;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: edge/centre waveforms, polarity, shadow timing,
// prescaler period, wrap/irq W1C and asynchronous reset.
module tb_pwm_multi_channel;

   localparam int NUM_CH = 8;
   localparam int ADDR_W = 4;

   logic              clk;
   logic              reset_n;
   logic              irq;
   logic [NUM_CH-1:0] pwm_out;
   int                n_chk;
   int                n_err;
   logic [31:0]       rdat;
   logic [63:0]       v0, v1, v2, vi;

   pwm_avs_if #(.NUM_CH(NUM_CH)) avs ();

   pwm_multi_channel #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (16),
      .PRESCALE_W (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .avs     (avs),
      .irq     (irq),
      .pwm_out (pwm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      avs.avs_address   = a;
      avs.avs_writedata = d;
      avs.avs_write     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      avs.avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d);
      avs.avs_address = a;
      avs.avs_read    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      avs.avs_read    = 1'b0;
      d = avs.avs_readdata;
   endtask

   // Samples channels 0..2 and irq at the current negedge, then advances one clock per sample.
   task automatic sample(input int n, output logic [63:0] s0, output logic [63:0] s1,
                         output logic [63:0] s2, output logic [63:0] si);
      s0 = 64'd0; s1 = 64'd0; s2 = 64'd0; si = 64'd0;
      for (int j = 0; j < n; j++) begin
         s0[j] = pwm_out[0];
         s1[j] = pwm_out[1];
         s2[j] = pwm_out[2];
         si[j] = irq;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      reset_n = 1'b0;
      avs.avs_address = 4'd0; avs.avs_write = 1'b0; avs.avs_writedata = 32'd0; avs.avs_read = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      check("rst_pwm", 64'(pwm_out), 64'h0);
      check("rst_irq", 64'(irq), 64'h0);
      check("rst_rdata", 64'(avs.avs_readdata), 64'h0);
      rd(4'd1, rdat);
      check("rst_period", 64'(rdat), 64'h0);

      // Edge mode, PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10
      wr(4'd1, 32'd9);
      wr(4'd2, 32'd0);
      wr(4'd4, 32'd3);
      wr(4'd5, 32'd0);
      wr(4'd6, 32'd10);
      wr(4'd0, 32'h1);
      sample(21, v0, v1, v2, vi);
      check("edge_ch0", v0, 64'h380E);
      check("edge_ch1_duty0", v1, 64'h0);
      check("edge_ch2_dutybig", v2, 64'h1FFFFE);

      wr(4'd0, 32'h5);
      @(negedge clk);
      sample(12, v0, v1, v2, vi);
      check("pol_ch1", v1, 64'hFFF);
      check("pol_ch2", v2, 64'h0);

      wr(4'd0, 32'h0);
      @(negedge clk);
      check("disable_pwm", 64'(pwm_out), 64'h0);
      rd(4'd3, rdat);
      check("wrap_set", 64'(rdat), 64'h1);
      check("irq_masked", 64'(irq), 64'h0);
      wr(4'd3, 32'h1);
      rd(4'd3, rdat);
      check("wrap_w1c", 64'(rdat), 64'h0);

      // Centre mode, PERIOD=4, DUTY0=2
      wr(4'd1, 32'd4);
      wr(4'd4, 32'd2);
      wr(4'd0, 32'h2);
      rd(4'd0, rdat);
      check("ctrl_readback", 64'(rdat), 64'h2);
      rd(4'd12, rdat);
      check("unmapped_read", 64'(rdat), 64'h0);
      wr(4'd0, 32'h3);
      sample(18, v0, v1, v2, vi);
      check("centre_ch0", v0, 64'h30706);

      // Mid-period DUTY0 3 -> 7 in edge mode
      wr(4'd0, 32'h0);
      wr(4'd1, 32'd9);
      wr(4'd4, 32'd3);
      wr(4'd0, 32'h1);
      wr(4'd4, 32'd7);
      rd(4'd4, rdat);
      check("duty_shadow_rb", 64'(rdat), 64'h7);
      sample(20, v0, v1, v2, vi);
      check("duty_commit_ch0", v0, 64'h8FE03);

      // PRESCALE=3, PERIOD=9 -> 40-clock period, irq enabled
      wr(4'd0, 32'h0);
      wr(4'd2, 32'd3);
      wr(4'd4, 32'd3);
      wr(4'd3, 32'h1);
      wr(4'd0, 32'h9);
      check("irq_before", 64'(irq), 64'h0);
      @(negedge clk);
      sample(40, v0, v1, v2, vi);
      check("presc_ch0", v0, 64'hFFF);
      check("presc_irq", vi, 64'h80_0000_0000);
      rd(4'd3, rdat);
      check("presc_wrap", 64'(rdat), 64'h1);
      wr(4'd3, 32'h1);
      rd(4'd3, rdat);
      check("presc_w1c", 64'(rdat), 64'h0);
      check("irq_cleared", 64'(irq), 64'h0);

      // Asynchronous reset mid-period with pol=1 and a read in flight
      wr(4'd0, 32'hD);
      @(negedge clk);
      @(negedge clk);
      avs.avs_address = 4'd1;
      avs.avs_read    = 1'b1;
      @(posedge clk);
      #2;
      check("pre_rst_rdata", 64'(avs.avs_readdata), 64'h9);
      check("pre_rst_pwm1", 64'(pwm_out[1]), 64'h1);
      reset_n = 1'b0;
      #1;
      check("async_rst_pwm", 64'(pwm_out), 64'h0);
      check("async_rst_irq", 64'(irq), 64'h0);
      check("async_rst_rdata", 64'(avs.avs_readdata), 64'h0);
      avs.avs_read = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd(4'd0, rdat);
      check("post_rst_ctrl", 64'(rdat), 64'h0);
      rd(4'd1, rdat);
      check("post_rst_period", 64'(rdat), 64'h0);
      rd(4'd2, rdat);
      check("post_rst_presc", 64'(rdat), 64'h0);
      rd(4'd3, rdat);
      check("post_rst_status", 64'(rdat), 64'h0);
      rd(4'd4, rdat);
      check("post_rst_duty0", 64'(rdat), 64'h0);
      rd(4'd6, rdat);
      check("post_rst_duty2", 64'(rdat), 64'h0);
      check("post_rst_pwm", 64'(pwm_out), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
